// File: rtl/pmp_mp_pkg.sv
// Shared definitions for the multi-port PMP checker: flag bit positions, region record, flush FSM states.
// Region addresses are held at the maximum supported width; narrower instances zero-extend.
package pmp_mp_pkg;

  localparam int PMP_FL_X = 0;
  localparam int PMP_FL_W = 1;
  localparam int PMP_FL_R = 2;
  localparam int PMP_FL_L = 3;
  localparam int PMP_FL_V = 4;
  localparam int PMP_FLAGS_W = 5;
  localparam int PMP_ADDR_MAX = 64;

  typedef struct packed {
    logic [PMP_FLAGS_W-1:0]  flags;
    logic [PMP_ADDR_MAX-1:0] start_addr;
    logic [PMP_ADDR_MAX-1:0] end_addr;
  } PmpRegionType;

  typedef enum logic {
    Flush_Idle = 1'b0,
    Flush_Clr  = 1'b1
  } FlushStateType;

  // Inclusive unsigned range test; an inverted range (end < start) can never be satisfied.
  function automatic logic pmp_in_range(input logic [PMP_ADDR_MAX-1:0] start_addr,
                                        input logic [PMP_ADDR_MAX-1:0] end_addr,
                                        input logic [PMP_ADDR_MAX-1:0] addr);
    return (start_addr <= addr) && (addr <= end_addr);
  endfunction

endpackage

// File: rtl/pmp_mp_match.sv
// One PMP region compared against one request address; purely combinational.
// Used NREG*NCH times by the checker, so it is kept to a pair of magnitude comparators.
module pmp_mp_match
  import pmp_mp_pkg::*;
(
  input  logic                    i_v,
  input  logic [PMP_ADDR_MAX-1:0] i_start_addr,
  input  logic [PMP_ADDR_MAX-1:0] i_end_addr,
  input  logic [PMP_ADDR_MAX-1:0] i_addr,
  output logic                    o_hit
);

  assign o_hit = i_v && pmp_in_range(i_start_addr, i_end_addr, i_addr);

endmodule

// File: rtl/pmp_checker_mp.sv
// PMP region table with NCH independent check channels; R/W/X grants return exactly 2 cycles after request.
// No back-pressure: every channel accepts one request per cycle; region writes are dropped while a flush runs.
module pmp_checker_mp
  import pmp_mp_pkg::*;
#(
  parameter int NREG = 16,
  parameter int NCH  = 3,
  parameter int AW   = 56
) (
  input  logic                    i_clk,
  input  logic                    i_nrst,
  input  logic                    i_we,
  input  logic [$clog2(NREG)-1:0] i_region,
  input  logic [AW-1:0]           i_start_addr,
  input  logic [AW-1:0]           i_end_addr,
  input  logic [PMP_FLAGS_W-1:0]  i_flags,
  input  logic                    i_flush,
  output logic                    o_busy,
  input  logic [NCH-1:0]          i_req_valid,
  input  logic [NCH*AW-1:0]       i_req_addr,
  input  logic [NCH-1:0]          i_req_mmode,
  output logic [NCH-1:0]          o_resp_valid,
  output logic [NCH-1:0]          o_resp_r,
  output logic [NCH-1:0]          o_resp_w,
  output logic [NCH-1:0]          o_resp_x,
  output logic [NCH-1:0]          o_resp_hit
);

  localparam int RIW = $clog2(NREG);

  PmpRegionType  regions [NREG];
  FlushStateType state_q, state_d;
  logic [RIW-1:0] cnt_q, cnt_d;
  logic           wr_en;
  logic           any_v;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      Flush_Idle: begin
        if (i_flush) begin
          state_d = Flush_Clr;
          cnt_d   = '0;
        end
      end
      Flush_Clr: begin
        cnt_d = cnt_q + RIW'(1);
        if (cnt_q == RIW'(NREG - 1)) state_d = Flush_Idle;
      end
      default: state_d = Flush_Idle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= Flush_Idle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_busy = (state_q == Flush_Clr);
  // A flush request in the same cycle wins over a region write.
  assign wr_en  = i_we && !o_busy && !i_flush && !regions[i_region].flags[PMP_FL_L];

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int r = 0; r < NREG; r++) regions[r] <= '0;
    end else if (o_busy) begin
      if (!regions[cnt_q].flags[PMP_FL_L]) regions[cnt_q] <= '0;
    end else if (wr_en) begin
      regions[i_region] <= '{flags:      i_flags,
                             start_addr: PMP_ADDR_MAX'(i_start_addr),
                             end_addr:   PMP_ADDR_MAX'(i_end_addr)};
    end
  end

  always_comb begin
    any_v = 1'b0;
    for (int r = 0; r < NREG; r++) any_v = any_v | regions[r].flags[PMP_FL_V];
  end

  logic [NREG-1:0] match_d [NCH];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    for (genvar r = 0; r < NREG; r++) begin : g_reg
      pmp_mp_match u_match (
        .i_v          (regions[r].flags[PMP_FL_V]),
        .i_start_addr (regions[r].start_addr),
        .i_end_addr   (regions[r].end_addr),
        .i_addr       (PMP_ADDR_MAX'(i_req_addr[c*AW +: AW])),
        .o_hit        (match_d[c][r])
      );
    end
  end

  // S1 snapshots the table flags alongside the match vector so a write landing
  // on the same edge cannot leak into a request already in flight.
  logic [NCH-1:0]  s1_vld;
  logic [NCH-1:0]  s1_mmode;
  logic [NREG-1:0] s1_match [NCH];
  logic [3:0]      s1_flags [NREG];
  logic            s1_any_v;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      s1_vld   <= '0;
      s1_mmode <= '0;
      s1_any_v <= 1'b0;
      for (int c = 0; c < NCH; c++) s1_match[c] <= '0;
      for (int r = 0; r < NREG; r++) s1_flags[r] <= '0;
    end else begin
      s1_vld   <= i_req_valid;
      s1_mmode <= i_req_mmode;
      s1_any_v <= any_v;
      for (int c = 0; c < NCH; c++) s1_match[c] <= match_d[c];
      for (int r = 0; r < NREG; r++) s1_flags[r] <= regions[r].flags[3:0];
    end
  end

  logic [NCH-1:0] gr_r, gr_w, gr_x, gr_hit;
  logic           hit_c;
  logic [3:0]     win_c;

  always_comb begin
    gr_r   = '0;
    gr_w   = '0;
    gr_x   = '0;
    gr_hit = '0;
    hit_c  = 1'b0;
    win_c  = '0;
    for (int c = 0; c < NCH; c++) begin
      hit_c = 1'b0;
      win_c = '0;
      // Descending scan leaves the lowest-index match as the winner.
      for (int r = NREG - 1; r >= 0; r--) begin
        if (s1_match[c][r]) begin
          hit_c = 1'b1;
          win_c = s1_flags[r];
        end
      end
      gr_hit[c] = hit_c;
      if (hit_c && (win_c[PMP_FL_L] || !s1_mmode[c])) begin
        {gr_r[c], gr_w[c], gr_x[c]} = win_c[2:0];
      end else if (hit_c || s1_mmode[c] || !s1_any_v) begin
        {gr_r[c], gr_w[c], gr_x[c]} = 3'b111;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_resp_valid <= '0;
      o_resp_r     <= '0;
      o_resp_w     <= '0;
      o_resp_x     <= '0;
      o_resp_hit   <= '0;
    end else begin
      o_resp_valid <= s1_vld;
      for (int c = 0; c < NCH; c++) begin
        if (s1_vld[c]) begin
          o_resp_r[c]   <= gr_r[c];
          o_resp_w[c]   <= gr_w[c];
          o_resp_x[c]   <= gr_x[c];
          o_resp_hit[c] <= gr_hit[c];
        end
      end
    end
  end

endmodule

// File: tb/tb_pmp_checker_mp.sv
// Directed and pseudo-random bench for pmp_checker_mp with a per-channel response scoreboard.
// Expected responses are queued at drive time and compared when the DUT raises o_resp_valid.
module tb_pmp_checker_mp;

  localparam int NREG = 16;
  localparam int NCH  = 3;
  localparam int AW   = 56;
  localparam int RIW  = 4;

  logic              i_clk;
  logic              i_nrst;
  logic              i_we;
  logic [RIW-1:0]    i_region;
  logic [AW-1:0]     i_start_addr;
  logic [AW-1:0]     i_end_addr;
  logic [4:0]        i_flags;
  logic              i_flush;
  logic              o_busy;
  logic [NCH-1:0]    i_req_valid;
  logic [NCH*AW-1:0] i_req_addr;
  logic [NCH-1:0]    i_req_mmode;
  logic [NCH-1:0]    o_resp_valid;
  logic [NCH-1:0]    o_resp_r;
  logic [NCH-1:0]    o_resp_w;
  logic [NCH-1:0]    o_resp_x;
  logic [NCH-1:0]    o_resp_hit;

  pmp_checker_mp #(.NREG(NREG), .NCH(NCH), .AW(AW)) dut (
    .i_clk        (i_clk),
    .i_nrst       (i_nrst),
    .i_we         (i_we),
    .i_region     (i_region),
    .i_start_addr (i_start_addr),
    .i_end_addr   (i_end_addr),
    .i_flags      (i_flags),
    .i_flush      (i_flush),
    .o_busy       (o_busy),
    .i_req_valid  (i_req_valid),
    .i_req_addr   (i_req_addr),
    .i_req_mmode  (i_req_mmode),
    .o_resp_valid (o_resp_valid),
    .o_resp_r     (o_resp_r),
    .o_resp_w     (o_resp_w),
    .o_resp_x     (o_resp_x),
    .o_resp_hit   (o_resp_hit)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Expected response word is {hit, r, w, x}.
  typedef struct {
    int         due;
    logic [3:0] hrwx;
  } exp_t;

  exp_t       sb [NCH][$];
  logic [3:0] last_out [NCH];

  logic [4:0]    m_flags [NREG];
  logic [AW-1:0] m_start [NREG];
  logic [AW-1:0] m_end   [NREG];
  bit            m_busy;
  int            m_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_resp(input logic [AW-1:0] a, input logic mm);
    logic anyv;
    anyv = 1'b0;
    for (int i = 0; i < NREG; i++) anyv = anyv | m_flags[i][4];
    for (int i = 0; i < NREG; i++) begin
      if (m_flags[i][4] && m_start[i] <= a && a <= m_end[i]) begin
        if (mm && !m_flags[i][3]) return 4'b1111;
        return {1'b1, m_flags[i][2:0]};
      end
    end
    if (mm || !anyv) return 4'b0111;
    return 4'b0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_flags[i] = '0;
      m_start[i] = '0;
      m_end[i]   = '0;
    end
    m_busy = 1'b0;
    m_cnt  = 0;
    for (int c = 0; c < NCH; c++) begin
      sb[c].delete();
      last_out[c] = '0;
    end
  endtask

  task automatic write_reg(input int r, input logic [AW-1:0] s, input logic [AW-1:0] e,
                           input logic [4:0] f);
    i_we         = 1'b1;
    i_region     = RIW'(r);
    i_start_addr = s;
    i_end_addr   = e;
    i_flags      = f;
  endtask

  task automatic drive_req(input int c, input logic [AW-1:0] a, input logic mm,
                           input logic [3:0] hrwx);
    exp_t e;
    i_req_valid[c]         = 1'b1;
    i_req_addr[c*AW +: AW] = a;
    i_req_mmode[c]         = mm;
    e.due  = cyc + 2;
    e.hrwx = hrwx;
    sb[c].push_back(e);
  endtask

  // Advance the reference table across the coming edge, then step to the next falling edge.
  task automatic cycle();
    if (m_busy) begin
      if (!m_flags[m_cnt][3]) begin
        m_flags[m_cnt] = '0;
        m_start[m_cnt] = '0;
        m_end[m_cnt]   = '0;
      end
      if (m_cnt == NREG - 1) m_busy = 1'b0;
      else m_cnt++;
    end else if (i_flush) begin
      m_busy = 1'b1;
      m_cnt  = 0;
    end else if (i_we && !m_flags[i_region][3]) begin
      m_flags[i_region] = i_flags;
      m_start[i_region] = i_start_addr;
      m_end[i_region]   = i_end_addr;
    end
    @(negedge i_clk);
    i_we        = 1'b0;
    i_flush     = 1'b0;
    i_req_valid = '0;
    chk("busy", o_busy, m_busy);
  endtask

  always @(negedge i_clk) begin
    if (i_nrst) begin
      for (int c = 0; c < NCH; c++) begin
        logic [3:0] got;
        exp_t       e;
        got = {o_resp_hit[c], o_resp_r[c], o_resp_w[c], o_resp_x[c]};
        if (o_resp_valid[c]) begin
          chk($sformatf("ch%0d_resp_pending", c), sb[c].size() > 0, 1);
          if (sb[c].size() > 0) begin
            e = sb[c].pop_front();
            chk($sformatf("ch%0d_latency", c), cyc, e.due);
            chk($sformatf("ch%0d_hrwx", c), got, e.hrwx);
          end
          last_out[c] = got;
        end else begin
          chk($sformatf("ch%0d_hold", c), got, last_out[c]);
        end
      end
    end
  end

  initial begin
    int            nbusy;
    logic [AW-1:0] a;
    logic          mm;

    i_nrst = 1'b0; i_we = 1'b0; i_region = '0; i_start_addr = '0; i_end_addr = '0;
    i_flags = '0; i_flush = 1'b0; i_req_valid = '0; i_req_addr = '0; i_req_mmode = '0;
    model_reset();
    repeat (3) @(negedge i_clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_resp_valid, 0);
    chk("rst_hrwx", {o_resp_hit, o_resp_r, o_resp_w, o_resp_x}, 0);
    i_nrst = 1'b1;
    cycle();

    // Empty table: user-mode access allowed everywhere, no hit.
    drive_req(0, 56'h1000, 1'b0, 4'b0111);
    cycle(); cycle(); cycle();

    // Region 0 R|X; a request on the same edge as the write still sees the empty table.
    write_reg(0, 56'h8000_0000, 56'h8000_FFFF, 5'b10101);
    drive_req(0, 56'h8000_0010, 1'b0, 4'b0111);
    cycle();
    drive_req(1, 56'h8000_0010, 1'b0, 4'b1101);
    drive_req(0, 56'h8000_FFFF, 1'b0, 4'b1101);
    drive_req(2, 56'h8001_0000, 1'b0, 4'b0000);
    cycle();
    drive_req(1, 56'h9000_0000, 1'b0, 4'b0000);
    drive_req(0, 56'h8000_0010, 1'b1, 4'b1111);
    drive_req(2, 56'h7FFF_FFFF, 1'b1, 4'b0111);
    cycle();

    // Locked reg2 beats reg5 and binds M-mode; rewriting a locked region is dropped.
    write_reg(2, 56'h2000, 56'h2FFF, 5'b11100);
    cycle();
    write_reg(5, 56'h1000, 56'h3FFF, 5'b10111);
    cycle();
    drive_req(2, 56'h2000, 1'b1, 4'b1100);
    drive_req(1, 56'h3000, 1'b1, 4'b1111);
    drive_req(0, 56'h3000, 1'b0, 4'b1111);
    cycle();
    write_reg(2, 56'h2000, 56'h2FFF, 5'b10111);
    cycle();
    drive_req(2, 56'h2000, 1'b1, 4'b1100);
    drive_req(0, 56'h2800, 1'b0, 4'b1100);
    cycle();
    write_reg(7, 56'h5000, 56'h4000, 5'b10111);
    cycle();
    drive_req(1, 56'h4800, 1'b0, 4'b0000);
    drive_req(0, 56'h5000, 1'b0, 4'b0000);
    cycle(); cycle(); cycle();

    // Reset clears locked regions as well.
    i_nrst = 1'b0;
    model_reset();
    @(negedge i_clk);
    i_nrst = 1'b1;
    cycle();
    drive_req(2, 56'h2000, 1'b1, 4'b0111);
    drive_req(0, 56'h2000, 1'b0, 4'b0111);
    cycle(); cycle(); cycle();

    // Fill all regions, lock 3 and 9, then flush; writes and flush requests during busy are ignored.
    for (int i = 0; i < NREG; i++) begin
      write_reg(i, AW'(i) << 16, (AW'(i) << 16) | 56'hFFFF,
                (i == 3 || i == 9) ? 5'b11100 : 5'b10100);
      cycle();
    end
    drive_req(0, 56'h5_0010, 1'b0, 4'b1100);
    drive_req(1, 56'h5_0010, 1'b1, 4'b1111);
    cycle();
    i_flush = 1'b1;
    write_reg(0, 56'h0, 56'hFFFF, 5'b10111);
    cycle();
    nbusy = 0;
    for (int k = 0; k < 40; k++) begin
      if (!o_busy) break;
      nbusy++;
      write_reg(0, 56'h0, 56'hFFFF, 5'b10111);
      if (k == 5) i_flush = 1'b1;
      cycle();
    end
    chk("flush_busy_cycles", nbusy, 16);
    drive_req(0, 56'h3_0010, 1'b0, 4'b1100);
    drive_req(1, 56'h9_0010, 1'b1, 4'b1100);
    drive_req(2, 56'h0_0010, 1'b0, 4'b0000);
    cycle();
    drive_req(0, 56'h5_0000, 1'b1, 4'b0111);
    drive_req(1, 56'h5_0000, 1'b0, 4'b0000);
    drive_req(2, 56'hF_FFFF, 1'b0, 4'b0000);
    cycle();

    // Back-to-back traffic on all channels with occasional table updates.
    write_reg(1, 56'h1_0000, 56'h1_FFFF, 5'b10010);
    cycle();
    write_reg(4, 56'h3_8000, 56'h4_FFFF, 5'b10111);
    cycle();
    for (int n = 0; n < 50; n++) begin
      if (n % 10 == 5)
        write_reg(6, 56'h6_0000, 56'h6_FFFF, {2'b10, 3'($urandom_range(0, 7))});
      for (int c = 0; c < NCH; c++) begin
        a  = (AW'($urandom_range(0, 11)) << 16) | AW'($urandom_range(0, 16'hFFFF));
        mm = 1'($urandom_range(0, 1));
        drive_req(c, a, mm, model_resp(a, mm));
      end
      cycle();
    end
    cycle(); cycle(); cycle();
    for (int c = 0; c < NCH; c++) chk($sformatf("ch%0d_drained", c), sb[c].size(), 0);

    // Reset asserted mid-flush with requests in flight.
    i_flush = 1'b1;
    cycle();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < NCH; c++) begin
        a = AW'(k * 16'h1000 + c * 16'h100) | 56'h3_0000;
        drive_req(c, a, 1'b0, model_resp(a, 1'b0));
      end
      if (k < 2) cycle();
    end
    #2;
    i_nrst = 1'b0;
    #1;
    chk("midrst_busy", o_busy, 0);
    chk("midrst_valid", o_resp_valid, 0);
    chk("midrst_hrwx", {o_resp_hit, o_resp_r, o_resp_w, o_resp_x}, 0);
    model_reset();
    i_we = 1'b0; i_flush = 1'b0; i_req_valid = '0;
    @(negedge i_clk);
    i_nrst = 1'b1;
    cycle();
    drive_req(0, 56'h3_0010, 1'b0, 4'b0111);
    drive_req(1, 56'h9_0010, 1'b1, 4'b0111);
    cycle(); cycle(); cycle();
    for (int c = 0; c < NCH; c++) chk($sformatf("ch%0d_final_drain", c), sb[c].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
